// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider.
// Contents:
//   div_state_e   - controller states (IDLE, BUSY, FINISH)
//   div_cnt_width - width of the iteration counter for a given operand width
//   DIV_ZERO_QUOT - all-ones quotient returned on divide-by-zero
package div_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    FINISH = 2'd2
  } div_state_e;

  // Counter must hold the value WIDTH itself.
  function automatic int unsigned div_cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  // All ones in the low 'width' bits (width 1..64).
  function automatic logic [63:0] DIV_ZERO_QUOT(input int unsigned width);
    return {64{1'b1}} >> (64 - width);
  endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Signed-mode helper for seq_divider (combinational).
// Ports:
//   sign        - operation is signed two's-complement
//   a, b        - raw dividend / divisor at accept time
//   a_mag_c     - dividend magnitude
//   b_mag_c     - divisor magnitude
//   neg_quot_c  - quotient must be negated (operand signs differ)
//   neg_rem_c   - remainder must be negated (dividend negative)
//   neg_quot_q  - registered neg_quot for the operation in flight
//   neg_rem_q   - registered neg_rem for the operation in flight
//   quot_raw    - unsigned quotient from the iteration
//   rem_raw     - unsigned remainder from the iteration
//   quot_fix_c  - sign-corrected quotient
//   rem_fix_c   - sign-corrected remainder
module div_sign_fix #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] a_mag_c,
  output logic [WIDTH-1:0] b_mag_c,
  output logic             neg_quot_c,
  output logic             neg_rem_c,
  input  logic             neg_quot_q,
  input  logic             neg_rem_q,
  input  logic [WIDTH-1:0] quot_raw,
  input  logic [WIDTH-1:0] rem_raw,
  output logic [WIDTH-1:0] quot_fix_c,
  output logic [WIDTH-1:0] rem_fix_c
);

  logic a_neg;
  logic b_neg;

  // Operand magnitudes; the most-negative value maps onto itself, which is
  // the correct unsigned magnitude 2^(WIDTH-1).
  always_comb begin
    a_neg      = sign & a[WIDTH-1];
    b_neg      = sign & b[WIDTH-1];
    a_mag_c    = a_neg ? (~a + WIDTH'(1)) : a;
    b_mag_c    = b_neg ? (~b + WIDTH'(1)) : b;
    neg_quot_c = a_neg ^ b_neg;
    neg_rem_c  = a_neg;
  end

  // Result negation; MIN / -1 wraps back to MIN naturally.
  always_comb begin
    quot_fix_c = neg_quot_q ? (~quot_raw + WIDTH'(1)) : quot_raw;
    rem_fix_c  = neg_rem_q  ? (~rem_raw  + WIDTH'(1)) : rem_raw;
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring integer divider, one quotient bit per clock.
// Optional feature macro: DIV_SIGNED_EN (honour 'sign' for two's-complement
// division); without it every operation is unsigned and 'sign' is ignored.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   start        - request, taken only while ready=1
//   sign         - signed operation (DIV_SIGNED_EN builds only)
//   a, b         - dividend / divisor, captured on accept
//   ready        - idle, able to accept
//   done         - one-cycle pulse when results update
//   quotient     - result quotient, held until next accept
//   remainder    - result remainder, held until next accept
//   div_by_zero  - captured divisor was zero, held until next accept
module seq_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  import div_pkg::*;

  localparam int unsigned CW = div_cnt_width(WIDTH);

  div_state_e       state;
  logic [WIDTH-1:0] dvd_q;       // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dvs_q;       // divisor magnitude
  logic [WIDTH-1:0] rem_q;       // partial remainder
  logic [WIDTH-1:0] a_raw_q;     // untouched dividend for the zero-divide result
  logic [CW-1:0]    cnt_q;
  logic             dz_q;
  logic             neg_quot_q;
  logic             neg_rem_q;

  logic [WIDTH-1:0] a_mag_c;
  logic [WIDTH-1:0] b_mag_c;
  logic             neg_quot_c;
  logic             neg_rem_c;
  logic [WIDTH-1:0] quot_fix_c;
  logic [WIDTH-1:0] rem_fix_c;

  logic [WIDTH:0]   rem_shift_c;
  logic [WIDTH:0]   diff_c;
  logic             take_c;

`ifdef DIV_SIGNED_EN
  div_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .sign       (sign),
    .a          (a),
    .b          (b),
    .a_mag_c    (a_mag_c),
    .b_mag_c    (b_mag_c),
    .neg_quot_c (neg_quot_c),
    .neg_rem_c  (neg_rem_c),
    .neg_quot_q (neg_quot_q),
    .neg_rem_q  (neg_rem_q),
    .quot_raw   (dvd_q),
    .rem_raw    (rem_q),
    .quot_fix_c (quot_fix_c),
    .rem_fix_c  (rem_fix_c)
  );
`else
  // Unsigned-only build: 'sign' stays on the port list but has no effect.
  logic unused_c;

  assign a_mag_c    = a;
  assign b_mag_c    = b;
  assign neg_quot_c = 1'b0;
  assign neg_rem_c  = 1'b0;
  assign quot_fix_c = dvd_q;
  assign rem_fix_c  = rem_q;
  assign unused_c   = sign ^ neg_quot_q ^ neg_rem_q;
`endif

  // One restoring step. Partial remainder is always < divisor, so the
  // shifted value fits WIDTH+1 bits and the subtractor's MSB is the borrow.
  always_comb begin
    rem_shift_c = {rem_q, dvd_q[WIDTH-1]};
    diff_c      = rem_shift_c - {1'b0, dvs_q};
    take_c      = ~diff_c[WIDTH];
  end

  // Controller, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ready       <= 1'b1;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      a_raw_q     <= '0;
      cnt_q       <= '0;
      dz_q        <= 1'b0;
      neg_quot_q  <= 1'b0;
      neg_rem_q   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ready      <= 1'b0;
            a_raw_q    <= a;
            dvd_q      <= a_mag_c;
            dvs_q      <= b_mag_c;
            rem_q      <= '0;
            neg_quot_q <= neg_quot_c;
            neg_rem_q  <= neg_rem_c;
            cnt_q      <= CW'(WIDTH);
            if (b == '0) begin
              dz_q  <= 1'b1;
              state <= FINISH;
            end else begin
              dz_q  <= 1'b0;
              state <= BUSY;
            end
          end
        end

        BUSY: begin
          rem_q <= take_c ? diff_c[WIDTH-1:0] : rem_shift_c[WIDTH-1:0];
          dvd_q <= {dvd_q[WIDTH-2:0], take_c};
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state <= FINISH;
          end
        end

        FINISH: begin
          done  <= 1'b1;
          ready <= 1'b1;
          state <= IDLE;
          if (dz_q) begin
            quotient    <= WIDTH'(DIV_ZERO_QUOT(WIDTH));
            remainder   <= a_raw_q;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= quot_fix_c;
            remainder   <= rem_fix_c;
            div_by_zero <= 1'b0;
          end
        end

        default: begin
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: a 32-bit and an 8-bit instance share
// clock and reset. Drivers push expected results when a request is
// accepted; monitors pop and compare on every done pulse.
module tb_seq_divider;

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    logic        dz;
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  logic        clk;
  logic        rst_n;

  logic        start32, sign32, ready32, done32, dz32;
  logic [31:0] a32, b32, quot32, rem32;

  logic        start8, sign8, ready8, done8, dz8;
  logic [7:0]  a8, b8, quot8, rem8;

  exp_t q32[$];
  exp_t q8[$];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done32_cnt = 0;
  logic done32_prev = 1'b0;
  logic done8_prev = 1'b0;

  seq_divider #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .sign(sign32), .a(a32), .b(b32),
    .ready(ready32), .done(done32), .quotient(quot32), .remainder(rem32),
    .div_by_zero(dz32)
  );

  seq_divider #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sign(sign8), .a(a8), .b(b8),
    .ready(ready8), .done(done8), .quotient(quot8), .remainder(rem8),
    .div_by_zero(dz8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_result(input exp_t e, input logic [63:0] q, input logic [63:0] r,
                              input logic dz);
    chk({e.name, " quotient"}, q, e.q);
    chk({e.name, " remainder"}, r, e.r);
    chk({e.name, " div_by_zero"}, 64'(dz), 64'(e.dz));
    chk({e.name, " latency"}, 64'(cyc - e.acc + 1), 64'(e.lat));
  endtask

  // Monitors: outputs are sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      done32_prev <= 1'b0;
    end else begin
      if (done32) begin
        done32_cnt <= done32_cnt + 1;
        chk("done32 single pulse", 64'(done32_prev), 64'(0));
        if (q32.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done32 unexpected: got done with no pending request");
        end else begin
          check_result(q32.pop_front(), 64'(quot32), 64'(rem32), dz32);
        end
      end
      done32_prev <= done32;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      done8_prev <= 1'b0;
    end else begin
      if (done8) begin
        chk("done8 single pulse", 64'(done8_prev), 64'(0));
        if (q8.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done8 unexpected: got done with no pending request");
        end else begin
          check_result(q8.pop_front(), 64'(quot8), 64'(rem8), dz8);
        end
      end
      done8_prev <= done8;
    end
  end

  // Waits for ready, presents one request for a single cycle, records expectation.
  task automatic issue(input bit w8, input logic [31:0] ia, input logic [31:0] ib,
                       input logic is, input logic [63:0] eq, input logic [63:0] er,
                       input logic edz, input string name);
    exp_t e;
    int   guard;
    guard = 0;
    @(negedge clk);
    while (!(w8 ? ready8 : ready32) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!(w8 ? ready8 : ready32)) begin
      checks++;
      errors++;
      $display("FAIL %s ready timeout: got ready=0 expected ready=1", name);
      return;
    end
    e.q    = eq;
    e.r    = er;
    e.dz   = edz;
    e.lat  = edz ? 2 : (w8 ? 10 : 34);
    e.acc  = cyc + 1;
    e.name = name;
    if (w8) begin
      start8 = 1'b1; a8 = ia[7:0]; b8 = ib[7:0]; sign8 = is;
      q8.push_back(e);
      @(negedge clk);
      start8 = 1'b0;
    end else begin
      start32 = 1'b1; a32 = ia; b32 = ib; sign32 = is;
      q32.push_back(e);
      @(negedge clk);
      start32 = 1'b0;
    end
  endtask

  initial begin
    exp_t        e;
    int          guard;
    int          cnt_before;
    logic [7:0]  ra, rb, rq, rr;
    logic        rs;

    clk = 1'b0;
    rst_n = 1'b0;
    start32 = 1'b0; sign32 = 1'b0; a32 = '0; b32 = '0;
    start8  = 1'b0; sign8  = 1'b0; a8  = '0; b8  = '0;

    repeat (3) @(negedge clk);
    chk("reset ready", 64'(ready32), 64'(1));
    chk("reset done", 64'(done32), 64'(0));
    chk("reset quotient", 64'(quot32), 64'(0));
    chk("reset remainder", 64'(rem32), 64'(0));
    chk("reset div_by_zero", 64'(dz32), 64'(0));
    chk("reset ready8", 64'(ready8), 64'(1));
    rst_n = 1'b1;

    // Unsigned and zero-divide vectors, WIDTH=32.
    issue(0, 32'd100, 32'd7, 1'b0, 64'd14, 64'd2, 1'b0, "u100_7");
    issue(0, 32'h12345678, 32'd0, 1'b0, 64'hFFFFFFFF, 64'h12345678, 1'b1, "dz32");
    issue(0, 32'hFFFFFFFF, 32'd1, 1'b0, 64'hFFFFFFFF, 64'd0, 1'b0, "max_div_1");
    issue(0, 32'd5, 32'd9, 1'b0, 64'd0, 64'd5, 1'b0, "small_div_big");
    issue(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'd1, 64'd0, 1'b0, "max_div_max");
    issue(0, 32'h80000000, 32'd3, 1'b0, 64'h2AAAAAAA, 64'd2, 1'b0, "min_div_3");
`ifdef DIV_SIGNED_EN
    issue(0, 32'hFFFFFFF9, 32'd2, 1'b1, 64'hFFFFFFFD, 64'hFFFFFFFF, 1'b0, "s_m7_2");
    issue(0, 32'd7, 32'hFFFFFFFE, 1'b1, 64'hFFFFFFFD, 64'd1, 1'b0, "s_7_m2");
    issue(0, 32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h80000000, 64'd0, 1'b0, "s_min_m1");
`else
    issue(0, 32'hFFFFFFF9, 32'd2, 1'b1, 64'h7FFFFFFC, 64'd1, 1'b0, "s_m7_2");
    issue(0, 32'd7, 32'hFFFFFFFE, 1'b1, 64'd0, 64'd7, 1'b0, "s_7_m2");
    issue(0, 32'h80000000, 32'hFFFFFFFF, 1'b1, 64'd0, 64'h80000000, 1'b0, "s_min_m1");
`endif
    issue(0, 32'hFFFFFFFB, 32'd0, 1'b1, 64'hFFFFFFFF, 64'hFFFFFFFB, 1'b1, "dz_signed");

    // Protocol: start held high with changing inputs while busy, then a
    // second request presented in the done cycle.
    guard = 0;
    @(negedge clk);
    while (!ready32 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    start32 = 1'b1; a32 = 32'd100; b32 = 32'd7; sign32 = 1'b0;
    e.q = 64'd14; e.r = 64'd2; e.dz = 1'b0; e.lat = 34; e.acc = cyc + 1; e.name = "hold_op1";
    q32.push_back(e);
    guard = 0;
    @(negedge clk);
    while (!ready32 && guard < 100) begin
      a32 = $urandom; b32 = $urandom; sign32 = 1'b1;
      @(negedge clk);
      guard++;
    end
    chk("b2b issued in done cycle", 64'(done32), 64'(1));
    a32 = 32'd50000; b32 = 32'd123; sign32 = 1'b0;
    e.q = 64'd406; e.r = 64'd62; e.dz = 1'b0; e.lat = 34; e.acc = cyc + 1; e.name = "b2b_op2";
    q32.push_back(e);
    @(negedge clk);
    start32 = 1'b0;

    // Reset abort at cycle 10 of an operation.
    issue(0, 32'hDEADBEEF, 32'd3, 1'b0, 64'd0, 64'd0, 1'b0, "aborted");
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    q32.delete();
    cnt_before = done32_cnt;
    #1;
    chk("abort ready", 64'(ready32), 64'(1));
    chk("abort done", 64'(done32), 64'(0));
    chk("abort quotient", 64'(quot32), 64'(0));
    chk("abort remainder", 64'(rem32), 64'(0));
    chk("abort div_by_zero", 64'(dz32), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort no done", 64'(done32_cnt - cnt_before), 64'(0));
    issue(0, 32'd1000, 32'd10, 1'b0, 64'd100, 64'd0, 1'b0, "after_abort");

    // WIDTH=8 instance.
    issue(1, 32'd255, 32'd16, 1'b0, 64'd15, 64'd15, 1'b0, "w8_255_16");
    issue(1, 32'd200, 32'd0, 1'b0, 64'hFF, 64'd200, 1'b1, "w8_dz");
    issue(1, 32'd7, 32'd200, 1'b0, 64'd0, 64'd7, 1'b0, "w8_7_200");

    // Random sweep against a behavioural model; requests issue back-to-back.
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = (i % 50 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      if (rb == 8'd0) begin
        rq = 8'hFF;
        rr = ra;
      end else begin
        rq = ra / rb;
        rr = ra % rb;
`ifdef DIV_SIGNED_EN
        if (rs) begin
          if (ra == 8'h80 && rb == 8'hFF) begin
            rq = 8'h80;
            rr = 8'h00;
          end else begin
            rq = 8'($signed(ra) / $signed(rb));
            rr = 8'($signed(ra) % $signed(rb));
          end
        end
`endif
      end
      issue(1, 32'(ra), 32'(rb), rs, 64'(rq), 64'(rr), (rb == 8'd0), "rnd8");
    end

    // Drain outstanding results.
    guard = 0;
    while ((q32.size() != 0 || q8.size() != 0) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (q32.size() != 0 || q8.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d/%0d pending results expected 0/0", q32.size(), q8.size());
    end
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
